szcv_flag_unit: RTL and testbench
=================================

// Module: szcv_flag_unit
// PURPOSE
//  Producer end of the SZCV condition-code interface: computes S/Z/C/V from execute-stage
//  operations and holds them in the architectural flag register feeding the branch decider.
//  Provides a same-cycle bypass so a branch directly after a flag-setting op sees fresh flags,
//  plus a one-deep shadow copy for interrupt entry/return. Sits between ALU and branch unit.
// PARAMETERS
//  W        16   datapath width of operands/result
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  ex_valid     in   1   execute stage holds a valid instruction this cycle
//  stall        in   1   pipeline stall; freezes all state updates
//  flag_op      in   3   flag operation class (see BEHAVIOUR)
//  op_a, op_b   in   W   ALU operands (ADD/SUB/CMP flag derivation)
//  alu_res      in   W   ALU result (LOGIC/SHIFT flag derivation)
//  shift_c      in   1   last bit shifted out (SHIFT carry)
//  int_save     in   1   interrupt entry: copy flags to shadow
//  int_restore  in   1   interrupt return: reload flags from shadow
//  szcv         out  4   registered flags {S,Z,C,V} = [3:0]
//  szcv_fwd     out  4   bypassed flags: value szcv will hold after this edge
//  shadow_full  out  1   shadow holds a saved copy
//  flag_err     out  1   sticky: save while full, or restore while empty
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): szcv=0, shadow=0, shadow_full=0, flag_err=0.
//  - flag_op: 000 NONE, 001 ADD, 010 SUB, 011 CMP, 100 LOGIC, 101 SHIFT, 110/111 NONE.
//  - upd = ex_valid & ~stall & op in {ADD,SUB,CMP,LOGIC,SHIFT}.
//  - ADD: r=op_a+op_b (W+1 bits); C=r[W]; V=(a[W-1]==b[W-1])&(r[W-1]!=a[W-1]).
//  - SUB/CMP: r=op_a-op_b; C=borrow=(op_a<op_b unsigned); V=(a[W-1]!=b[W-1])&(r[W-1]!=a[W-1]).
//  - ADD/SUB/CMP: S=r[W-1], Z=(r[W-1:0]==0), from internally computed r (alu_res ignored).
//  - LOGIC: S=alu_res[W-1], Z=(alu_res==0), C=0, V=0. SHIFT: as LOGIC but C=shift_c.
//  - new_flags: computed value if upd, else szcv. szcv <= next value at edge; latency 1.
//  - szcv_fwd combinational = next szcv value (incl. restore), zero-cycle bypass.
//  - Priority when ~stall: int_restore > upd. Restore with shadow_full: szcv<=shadow,
//    shadow_full<=0, concurrent upd discarded. Restore with empty shadow: no change, flag_err<=1.
//  - int_save (~stall, ~int_restore): if ~shadow_full, shadow<=new_flags (post-update value
//    when upd same cycle), shadow_full<=1; if full: shadow kept, flag_err<=1. save&restore
//    together: restore only, flag_err<=1.
//  - stall=1: no register changes; szcv_fwd=szcv.
//  - flag_err cleared only by reset.
// STRUCTURE
//  - Shared package: flag_op encodings, SZCV bit indices (S=3,Z=2,C=1,V=0), W default.
//  - One sub-module natural: szcv_calc (pure combinational flag derivation per flag_op);
//    top holds flag register, shadow register, priority logic and bypass mux.
// TESTING (W=16)
//  - ADD 0x7FFF+0x0001 -> szcv_fwd=1001 same cycle, szcv=1001 next cycle.
//  - SUB 0x0003-0x0003 -> 0100; CMP 0x0001-0x0002 -> 1010; ADD 0xFFFF+0x0001 -> 0110.
//  - LOGIC alu_res=0x0000 after flags=1111 -> 0100; SHIFT alu_res=0x8000,shift_c=1 -> 1010.
//  - stall=1 with ADD 0x7FFF+1, ex_valid=1 -> szcv unchanged, szcv_fwd=szcv; ex_valid=0 -> no update.
//  - flags=0100, int_save with SUB 0x0001-0x0002 -> shadow=1010, szcv=1010; LOGIC 0 -> 0100;
//    int_restore with ADD same cycle -> szcv=1010, shadow_full=0; 2nd restore -> flag_err=1.
//  - rst_n low mid-sequence (shadow_full=1, flag_err=1) -> all outputs 0 immediately, async.

Source files
------------

// File: rtl/szcv_flag_unit_pkg.sv
// Shared definitions for the SZCV condition-code producer: flag-op encodings,
// flag bit positions and the default datapath width.
package szcv_flag_unit_pkg;

   localparam int W_DEFAULT = 16;

   localparam int FLAG_S = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [2:0] {
      FOP_NONE  = 3'b000,
      FOP_ADD   = 3'b001,
      FOP_SUB   = 3'b010,
      FOP_CMP   = 3'b011,
      FOP_LOGIC = 3'b100,
      FOP_SHIFT = 3'b101,
      FOP_RSV6  = 3'b110,
      FOP_RSV7  = 3'b111
   } flag_op_e;

   // True for the op classes that write the flag register.
   function automatic logic op_sets_flags(input logic [2:0] op);
      logic sets;
      case (op)
         FOP_ADD, FOP_SUB, FOP_CMP, FOP_LOGIC, FOP_SHIFT: sets = 1'b1;
         default:                                         sets = 1'b0;
      endcase
      return sets;
   endfunction

endpackage

// File: rtl/szcv_flag_unit_calc.sv
// Pure combinational S/Z/C/V derivation for one execute-stage flag operation.
// Arithmetic ops recompute the result from the operands; LOGIC/SHIFT use alu_res.
module szcv_flag_unit_calc
   import szcv_flag_unit_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [2:0]   flag_op,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [W-1:0] alu_res,
   input  logic         shift_c,
   output logic [3:0]   flags,
   output logic         sets_flags
);

   logic [W:0] sum;
   logic [W:0] diff;
   logic       a_msb;
   logic       b_msb;

   assign a_msb = op_a[W-1];
   assign b_msb = op_b[W-1];

   // Zero-extended W+1 bit arithmetic: sum[W] is carry-out, diff[W] is borrow (a < b).
   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};

   assign sets_flags = op_sets_flags(flag_op);

   always_comb begin
      flags = 4'b0000;
      case (flag_op)
         FOP_ADD: begin
            flags[FLAG_S] = sum[W-1];
            flags[FLAG_Z] = (sum[W-1:0] == '0);
            flags[FLAG_C] = sum[W];
            flags[FLAG_V] = (a_msb == b_msb) & (sum[W-1] != a_msb);
         end
         FOP_SUB, FOP_CMP: begin
            flags[FLAG_S] = diff[W-1];
            flags[FLAG_Z] = (diff[W-1:0] == '0);
            flags[FLAG_C] = diff[W];
            flags[FLAG_V] = (a_msb != b_msb) & (diff[W-1] != a_msb);
         end
         FOP_LOGIC: begin
            flags[FLAG_S] = alu_res[W-1];
            flags[FLAG_Z] = (alu_res == '0);
         end
         FOP_SHIFT: begin
            flags[FLAG_S] = alu_res[W-1];
            flags[FLAG_Z] = (alu_res == '0);
            flags[FLAG_C] = shift_c;
         end
         default: flags = 4'b0000;
      endcase
   end

endmodule

// File: rtl/szcv_flag_unit.sv
// Architectural SZCV flag register with zero-cycle bypass and a one-deep
// shadow copy used across interrupt entry/return.
module szcv_flag_unit
   import szcv_flag_unit_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ex_valid,
   input  logic         stall,
   input  logic [2:0]   flag_op,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [W-1:0] alu_res,
   input  logic         shift_c,
   input  logic         int_save,
   input  logic         int_restore,
   output logic [3:0]   szcv,
   output logic [3:0]   szcv_fwd,
   output logic         shadow_full,
   output logic         flag_err
);

   logic [3:0] calc_flags;
   logic       calc_sets;
   logic       upd;
   logic [3:0] new_flags;

   logic [3:0] shadow;
   logic [3:0] szcv_nxt;
   logic [3:0] shadow_nxt;
   logic       full_nxt;
   logic       err_nxt;

   szcv_flag_unit_calc #(.W(W)) u_calc (
      .flag_op    (flag_op),
      .op_a       (op_a),
      .op_b       (op_b),
      .alu_res    (alu_res),
      .shift_c    (shift_c),
      .flags      (calc_flags),
      .sets_flags (calc_sets)
   );

   assign upd       = ex_valid & ~stall & calc_sets;
   assign new_flags = upd ? calc_flags : szcv;

   // Restore outranks both the flag update and a concurrent save; stall freezes everything.
   always_comb begin
      szcv_nxt   = szcv;
      shadow_nxt = shadow;
      full_nxt   = shadow_full;
      err_nxt    = flag_err;
      if (!stall) begin
         if (int_restore) begin
            if (shadow_full) begin
               szcv_nxt = shadow;
               full_nxt = 1'b0;
            end else begin
               err_nxt = 1'b1;
            end
            if (int_save) err_nxt = 1'b1;
         end else begin
            szcv_nxt = new_flags;
            if (int_save) begin
               if (!shadow_full) begin
                  shadow_nxt = new_flags;
                  full_nxt   = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
      end
   end

   assign szcv_fwd = szcv_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         szcv        <= 4'b0000;
         shadow      <= 4'b0000;
         shadow_full <= 1'b0;
         flag_err    <= 1'b0;
      end else begin
         szcv        <= szcv_nxt;
         shadow      <= shadow_nxt;
         shadow_full <= full_nxt;
         flag_err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_szcv_flag_unit.sv
// Directed bench for szcv_flag_unit (W=16) with hand-computed expected flags.
module tb_szcv_flag_unit;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         ex_valid;
   logic         stall;
   logic [2:0]   flag_op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] alu_res;
   logic         shift_c;
   logic         int_save;
   logic         int_restore;
   logic [3:0]   szcv;
   logic [3:0]   szcv_fwd;
   logic         shadow_full;
   logic         flag_err;

   int checks = 0;
   int errors = 0;

   szcv_flag_unit #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_valid    (ex_valid),
      .stall       (stall),
      .flag_op     (flag_op),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_res     (alu_res),
      .shift_c     (shift_c),
      .int_save    (int_save),
      .int_restore (int_restore),
      .szcv        (szcv),
      .szcv_fwd    (szcv_fwd),
      .shadow_full (shadow_full),
      .flag_err    (flag_err)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic idle();
      ex_valid    = 1'b0;
      stall       = 1'b0;
      flag_op     = 3'b000;
      op_a        = '0;
      op_b        = '0;
      alu_res     = '0;
      shift_c     = 1'b0;
      int_save    = 1'b0;
      int_restore = 1'b0;
   endtask

   // Drives one cycle's inputs at the falling edge and lets them settle.
   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic sc, input logic valid,
                        input logic stl, input logic sv, input logic rs);
      @(negedge clk);
      flag_op     = op;
      op_a        = a;
      op_b        = b;
      alu_res     = res;
      shift_c     = sc;
      ex_valid    = valid;
      stall       = stl;
      int_save    = sv;
      int_restore = rs;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #3;
      check("reset_szcv", szcv, 4'b0000);
      check("reset_fwd", szcv_fwd, 4'b0000);
      check("reset_full", {3'b0, shadow_full}, 4'b0000);
      check("reset_err", {3'b0, flag_err}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD overflow into sign
      drive(3'b001, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("add_ovf_fwd", szcv_fwd, 4'b1001);
      check("add_ovf_pre", szcv, 4'b0000);
      tick();
      check("add_ovf_reg", szcv, 4'b1001);

      drive(3'b010, 16'h0003, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sub_zero_fwd", szcv_fwd, 4'b0100);
      tick();
      check("sub_zero_reg", szcv, 4'b0100);

      drive(3'b011, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("cmp_borrow", szcv, 4'b1010);

      drive(3'b001, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("add_carry", szcv, 4'b0110);

      // LOGIC clears a previously set carry
      drive(3'b100, 16'h0, 16'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("logic_zero", szcv, 4'b0100);

      drive(3'b101, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("shift_neg_c", szcv, 4'b1010);

      // Stall freezes the register and bypass shows the held value
      drive(3'b001, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_fwd", szcv_fwd, 4'b1010);
      tick();
      check("stall_reg", szcv, 4'b1010);

      drive(3'b001, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("novalid_fwd", szcv_fwd, 4'b1010);
      tick();
      check("novalid_reg", szcv, 4'b1010);

      drive(3'b110, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("rsv_op_reg", szcv, 4'b1010);

      // Interrupt save / restore
      drive(3'b100, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("pre_save", szcv, 4'b0100);

      drive(3'b010, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("save_fwd", szcv_fwd, 4'b1010);
      tick();
      check("save_reg", szcv, 4'b1010);
      check("save_full", {3'b0, shadow_full}, 4'b0001);

      drive(3'b100, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("isr_logic", szcv, 4'b0100);

      // Restore while stalled does nothing
      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check("stall_rst_reg", szcv, 4'b0100);
      check("stall_rst_full", {3'b0, shadow_full}, 4'b0001);

      drive(3'b001, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("restore_fwd", szcv_fwd, 4'b1010);
      tick();
      check("restore_reg", szcv, 4'b1010);
      check("restore_full", {3'b0, shadow_full}, 4'b0000);
      check("restore_err", {3'b0, flag_err}, 4'b0000);

      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("empty_rst_err", {3'b0, flag_err}, 4'b0001);
      check("empty_rst_reg", szcv, 4'b1010);

      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("resave_full", {3'b0, shadow_full}, 4'b0001);

      // Asynchronous reset between clock edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_szcv", szcv, 4'b0000);
      check("async_full", {3'b0, shadow_full}, 4'b0000);
      check("async_err", {3'b0, flag_err}, 4'b0000);
      check("async_fwd", szcv_fwd, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Save while full: shadow kept, error raised
      drive(3'b001, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("save1_reg", szcv, 4'b1001);
      drive(3'b010, 16'h0003, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("save2_reg", szcv, 4'b0100);
      check("save2_err", {3'b0, flag_err}, 4'b0001);
      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("kept_shadow", szcv, 4'b1001);

      // Save and restore together: restore wins, error raised
      do_reset();
      drive(3'b001, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("sr_setup", szcv, 4'b0110);
      drive(3'b100, 16'h0, 16'h0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("sr_logic", szcv, 4'b1000);
      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check("sr_reg", szcv, 4'b0110);
      check("sr_full", {3'b0, shadow_full}, 4'b0000);
      check("sr_err", {3'b0, flag_err}, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
